// File: rtl/quad_pkg.sv
// +----------------------------------------------------------------------------+
// | quad_pkg                                                                   |
// | Register addresses and 2-bit quadrature state encodings for the filter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package quad_pkg;

  localparam logic [15:0] ADDR_STATUS  = 16'h0000;
  localparam logic [15:0] ADDR_ERR_CNT = 16'h0001;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_t;

  // Clockwise order is 00 -> 01 -> 11 -> 10 -> 00, state bits are {a, b}
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      QS_00:   cw_next = QS_01;
      QS_01:   cw_next = QS_11;
      QS_11:   cw_next = QS_10;
      default: cw_next = QS_00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] s);
    case (s)
      QS_00:   ccw_next = QS_10;
      QS_10:   ccw_next = QS_11;
      QS_11:   ccw_next = QS_01;
      default: ccw_next = QS_00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_input_filter_if.sv
// +----------------------------------------------------------------------------+
// | quad_input_filter_if                                                       |
// | Register read bus and error-clear strobe of the quadrature input filter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface quad_input_filter_if;
  logic [15:0] addr;
  logic        cs;
  logic        rd;
  logic        clr_err;
  logic [7:0]  data_out;

  modport master (
    output addr, cs, rd, clr_err,
    input  data_out
  );

  modport slave (
    input  addr, cs, rd, clr_err,
    output data_out
  );
endinterface

`default_nettype wire

// File: rtl/glitch_filter.sv
// +----------------------------------------------------------------------------+
// | glitch_filter                                                              |
// | 2-flop synchronizer followed by a FILTER_LEN-cycle stability counter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  raw,
  input  wire  bypass,
  output logic clean
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // During bypass the clean level tracks the synchronizer so power-up levels settle silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      clean <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (bypass) begin
        clean <= sync2;
        cnt   <= 8'd0;
      end else if (sync2 == clean) begin
        cnt   <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        clean <= sync2;
        cnt   <= 8'd0;
      end else begin
        cnt   <= cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/quad_input_filter.sv
// +----------------------------------------------------------------------------+
// | quad_input_filter                                                          |
// | Debounced x4 quadrature decoder with error flagging and register reads.   |
// | Optional macro QUAD_ERR_COUNT_EN adds the saturating 8-bit error counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  A,
  input  wire                  B,
  quad_input_filter_if.slave   bus,
  output logic                 step_cw,
  output logic                 step_ccw,
  output logic                 dir,
  output logic                 a_clean,
  output logic                 b_clean,
  output logic                 err
);

  import quad_pkg::*;

  localparam logic [0:0] PH_INIT   = 1'b0;
  localparam logic [0:0] PH_RUN    = 1'b1;
  localparam logic [8:0] INIT_LAST = 9'(FILTER_LEN + 1);

  logic [0:0] phase;
  logic [0:0] phase_next;
  logic [8:0] init_cnt;
  logic       bypass;

  logic       run_q;
  logic [1:0] cur;
  logic [1:0] prev;
  logic       moved;
  logic       err_sticky;
  logic [7:0] err_cnt;

  // Init phase lasts 2+FILTER_LEN cycles after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_INIT;
      init_cnt <= 9'd0;
    end else begin
      phase <= phase_next;
      if (phase == PH_INIT) begin
        init_cnt <= init_cnt + 9'd1;
      end
    end
  end

  always_comb begin
    phase_next = phase;
    if ((phase == PH_INIT) && (init_cnt == INIT_LAST)) begin
      phase_next = PH_RUN;
    end
  end

  always_comb begin
    bypass = (phase == PH_INIT);
  end

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (A),
    .bypass (bypass),
    .clean  (a_clean)
  );

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (B),
    .bypass (bypass),
    .clean  (b_clean)
  );

  assign cur   = {a_clean, b_clean};
  assign moved = run_q && (cur != prev);

  // run_q lags the phase by one cycle so the last init-phase level change is never decoded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= QS_00;
      run_q    <= 1'b0;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      err      <= 1'b0;
      dir      <= 1'b0;
    end else begin
      prev     <= cur;
      run_q    <= ~bypass;
      step_cw  <= moved && (cur == cw_next(prev));
      step_ccw <= moved && (cur == ccw_next(prev));
      err      <= moved && (cur == ~prev);
      if (moved && (cur == cw_next(prev))) begin
        dir <= 1'b1;
      end else if (moved && (cur == ccw_next(prev))) begin
        dir <= 1'b0;
      end
    end
  end

  // Error bookkeeping follows the err pulse by one cycle, so a clear in the same cycle loses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err) begin
      err_sticky <= 1'b1;
    end else if (bus.clr_err) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef QUAD_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (err) begin
      if (bus.clr_err) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (bus.clr_err) begin
      err_cnt <= 8'd0;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= 8'h00;
    end else if (bus.cs && bus.rd) begin
      case (bus.addr)
        ADDR_STATUS:  bus.data_out <= {4'b0000, err_sticky, dir, b_clean, a_clean};
        ADDR_ERR_CNT: bus.data_out <= err_cnt;
        default:      bus.data_out <= 8'h00;
      endcase
    end else begin
      bus.data_out <= 8'h00;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quad_input_filter.sv
// +----------------------------------------------------------------------------+
// | tb_quad_input_filter                                                       |
// | Self-checking bench: vector tables plus a pulse scoreboard.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_quad_input_filter;

  localparam int FILTER_LEN = 4;
  localparam int LAT        = FILTER_LEN + 3;
  localparam int K_CW       = 0;
  localparam int K_CCW      = 1;
  localparam int K_ERR      = 2;
  localparam int K_NONE     = -1;

`ifdef QUAD_ERR_COUNT_EN
  localparam logic [7:0] EXP_CNT1   = 8'h01;
  localparam logic [7:0] EXP_CNTMAX = 8'hFF;
`else
  localparam logic [7:0] EXP_CNT1   = 8'h00;
  localparam logic [7:0] EXP_CNTMAX = 8'h00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic A     = 1'b0;
  logic B     = 1'b0;
  logic step_cw, step_ccw, dir, a_clean, b_clean, err;

  quad_input_filter_if bus();

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .bus      (bus),
    .step_cw  (step_cw),
    .step_ccw (step_ccw),
    .dir      (dir),
    .a_clean  (a_clean),
    .b_clean  (b_clean),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int due;
  } exp_t;

  typedef struct {
    logic [1:0] ab;
    int         kind;
  } step_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  want;
  } rd_vec_t;

  exp_t      sbq[$];
  step_vec_t vecs[$];
  rd_vec_t   rds[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int n_cw   = 0;
  int n_ccw  = 0;
  int n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int kind);
    {A, B} = ab;
    if (kind != K_NONE) sbq.push_back('{kind, cyc + LAT});
  endtask

  task automatic read_chk(input string name, input logic [15:0] a, input logic [7:0] want);
    bus.addr = a;
    bus.cs   = 1'b1;
    bus.rd   = 1'b1;
    tick(1);
    check(name, int'(bus.data_out), int'(want));
    bus.cs = 1'b0;
    bus.rd = 1'b0;
    tick(1);
    check({name, "_idle"}, int'(bus.data_out), 0);
  endtask

  task automatic pulse_clr;
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(1);
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, int'({step_cw, step_ccw, dir, a_clean, b_clean, err, bus.data_out}), 0);
  endtask

  // Every pulse is matched in order against the scoreboard, with kind and exact cycle
  always @(negedge clk) begin
    if (rst_n && (step_cw || step_ccw || err)) begin
      int   kind;
      exp_t e;
      kind = step_cw ? K_CW : (step_ccw ? K_CCW : K_ERR);
      if (step_cw)  n_cw++;
      if (step_ccw) n_ccw++;
      if (err)      n_err++;
      check("pulse_exclusive", int'($onehot0({step_cw, step_ccw, err})), 1);
      if (sbq.size() == 0) begin
        check("unexpected_pulse", kind, K_NONE);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int c;
    for (int r = 0; r < 3; r++) begin
      vecs.push_back('{2'b01, K_CW});
      vecs.push_back('{2'b11, K_CW});
      vecs.push_back('{2'b10, K_CW});
      vecs.push_back('{2'b00, K_CW});
    end
    for (int r = 0; r < 5; r++) begin
      vecs.push_back('{2'b10, K_CCW});
      vecs.push_back('{2'b11, K_CCW});
      vecs.push_back('{2'b01, K_CCW});
      vecs.push_back('{2'b00, K_CCW});
    end
    rds.push_back('{16'h0000, 8'h0B});
    rds.push_back('{16'h0001, EXP_CNT1});
    rds.push_back('{16'h0002, 8'h00});
    rds.push_back('{16'h8000, 8'h00});

    bus.addr    = 16'h0000;
    bus.cs      = 1'b0;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;

    #2 rst_n = 1'b0;
    tick(3);
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;
    tick(FILTER_LEN + 6);
    check("post_init_clean", int'({a_clean, b_clean}), 0);

    for (int i = 0; i < 12; i++) begin
      drive_ab(vecs[i].ab, vecs[i].kind);
      tick(10);
    end
    check("cw_count", n_cw, 12);
    check("cw_no_ccw", n_ccw, 0);
    check("cw_dir", int'(dir), 1);

    for (int i = 12; i < vecs.size(); i++) begin
      drive_ab(vecs[i].ab, vecs[i].kind);
      tick(10);
    end
    check("ccw_count", n_ccw, 20);
    check("ccw_dir", int'(dir), 0);
    check("rotation_no_err", n_err, 0);

    // A three-cycle glitch never reaches the four-cycle stability threshold
    A = 1'b1;
    tick(3);
    A = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("glitch_a_clean", int'(a_clean), 0);
      tick(1);
    end
    check("glitch_no_step", n_cw + n_ccw, 32);

    drive_ab(2'b11, K_ERR);
    tick(10);
    check("jump_err_count", n_err, 1);
    check("jump_dir_kept", int'(dir), 0);
    check("jump_clean", int'({a_clean, b_clean}), 3);
    for (int i = 0; i < rds.size(); i++) read_chk($sformatf("read_%0d", i), rds[i].addr, rds[i].want);
    pulse_clr();
    read_chk("clr_status", 16'h0000, 8'h03);
    read_chk("clr_errcnt", 16'h0001, 8'h00);

    drive_ab(2'b00, K_ERR);
    c = cyc;
    tick(LAT);
    check("coinc_err_high", int'(err), 1);
    check("coinc_timing", cyc - c, LAT);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(2);
    read_chk("coinc_status", 16'h0000, 8'h08);
    read_chk("coinc_errcnt", 16'h0001, EXP_CNT1);

    pulse_clr();
    for (int i = 0; i < 300; i++) begin
      drive_ab((i % 2 == 0) ? 2'b11 : 2'b00, K_ERR);
      tick(10);
    end
    check("many_err_count", n_err, 302);
    read_chk("sat_errcnt", 16'h0001, EXP_CNTMAX);
    read_chk("sat_status", 16'h0000, 8'h08);

    // Reset in the middle of a pending 00->01 step must drop it silently
    drive_ab(2'b01, K_NONE);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset_outputs");
    {A, B} = 2'b11;
    tick(5);
    check_zero_outputs("held_reset_outputs");
    rst_n = 1'b1;
    tick(FILTER_LEN + 8);
    check("release_11_clean", int'({a_clean, b_clean}), 3);
    check("release_no_step", n_cw + n_ccw, 32);
    check("release_no_err", n_err, 302);

    drive_ab(2'b10, K_CW);
    tick(10);
    check("after_reset_cw", n_cw, 13);
    check("after_reset_dir", int'(dir), 1);

    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/quad_input_filter.md
QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

Interface
REQ-001 Parameter FILTER_LEN, default 4, meaning consecutive stable cycles needed before a channel change is accepted (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 A, B  input  1 each  raw asynchronous quadrature encoder channels.
REQ-005 clr_err  input  1  synchronous pulse; clears err_sticky and err_cnt.
REQ-006 addr  input  16  bus read address.
REQ-007 cs, rd  input  1 each  bus chip-select and read strobe.
REQ-008 data_out  output  8  registered bus read data.
REQ-009 step_cw, step_ccw  output  1 each  one-cycle step pulses to the downstream step counter.
REQ-010 dir  output  1  direction of last valid step (1 = CW).
REQ-011 a_clean, b_clean  output  1 each  filtered channel levels.
REQ-012 err  output  1  one-cycle pulse on an illegal transition.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer.
REQ-014 Each channel's clean level SHALL take the synchronized value only after that value has differed from the clean level for FILTER_LEN consecutive edges; any reversion restarts the count.
REQ-015 Decode state SHALL be {a_clean,b_clean}; CW order 00->01->11->10->00, CCW is the reverse.
REQ-016 Every valid one-position CW transition SHALL assert step_cw for exactly one cycle, set dir=1; CCW likewise with step_ccw, dir=0 (x4 decoding).
REQ-017 Latency from a clean raw edge to the step pulse SHALL be exactly 2+FILTER_LEN+1 cycles.
REQ-018 A two-position jump (00<->11, 01<->10) SHALL assert err for one cycle, no step pulse, dir unchanged, set err_sticky.
REQ-019 step_cw, step_ccw and err SHALL be mutually exclusive in every cycle.
REQ-020 err_cnt (8-bit) SHALL increment on each err and saturate at 255.
REQ-021 clr_err coincident with err SHALL leave err_cnt=1 and err_sticky=1.
REQ-022 When cs&rd is sampled high, data_out SHALL update next edge: addr 0x0000 -> {4'b0, err_sticky, dir, b_clean, a_clean}; 0x0001 -> err_cnt; any other addr -> 0x00.
REQ-023 When cs&rd is low, data_out SHALL be 0x00 on the next edge.

Reset
REQ-024 While rst_n is low: all outputs 0, synchronizers, filter counters, err_cnt, err_sticky, clean levels 0.
REQ-025 For the first 2+FILTER_LEN cycles after rst_n deasserts (init phase), clean levels SHALL follow the synchronized inputs directly, with no step or err pulses.
REQ-026 Reset asserted mid-transition SHALL abort it immediately with no pulse emitted.

Configuration
REQ-027 Macro QUAD_ERR_COUNT_EN: defined -> err_cnt implemented per REQ-020/021; undefined -> no counter logic, addr 0x0001 reads 0x00; err and err_sticky unaffected.

Structure
REQ-028 Shared package quad_pkg SHALL hold the register address constants (0x0000, 0x0001) and the 2-bit quadrature state encodings.
REQ-029 Sub-module glitch_filter (synchronizer + stability counter, FILTER_LEN parameter) SHALL be instantiated once per channel.

Verification
REQ-030 FILTER_LEN=4, inputs 00 at reset, 3 full CW cycles at 10 cycles per state -> 12 step_cw pulses, 0 step_ccw, dir=1, each 7 cycles after its raw edge.
REQ-031 5 full CCW cycles -> 20 step_ccw pulses, dir=0, err never asserted.
REQ-032 A pulse high for 3 cycles from state 00 -> no change to a_clean, no pulses.
REQ-033 Raw 00->11 with both channels changing together -> one err pulse, no step, read 0x0000 gives bit3=1, read 0x0001 gives 0x01; clr_err -> both read 0.
REQ-034 300 forced illegal jumps -> err_cnt reads 0xFF; without QUAD_ERR_COUNT_EN, 0x0001 reads 0x00.
REQ-035 Inputs held 11 through reset release -> clean=11 after init phase, no err or step pulse.
